// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master drives operands and start; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  start;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Diff;
    logic                  Borrow;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Borrow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B, LSB first, one bit per clock.
// A single 1-bit subtract cell plus a borrow flop, sequenced by an IDLE/RUN/DONE FSM.
module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic                  accept;
    logic [DATA_WIDTH-1:0] a_sr_reg;
    logic [DATA_WIDTH-1:0] b_sr_reg;
    logic [DATA_WIDTH-1:0] res_reg;
    logic [DATA_WIDTH-1:0] res_next;
    logic [DATA_WIDTH-1:0] diff_reg;
    logic                  br_reg;
    logic                  br_next;
    logic                  borrow_reg;
    logic                  d_bit;
    logic                  last_bit;
    logic [CW-1:0]         cnt_reg;
    logic                  a_bit;
    logic                  b_bit;

    assign a_bit    = a_sr_reg[0];
    assign b_bit    = b_sr_reg[0];
    assign d_bit    = a_bit ^ b_bit ^ br_reg;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
    assign last_bit = (cnt_reg == CW'(DATA_WIDTH - 1));

    // Result register shifts right; the freshly computed bit enters at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_res_shift
            assign res_next[gi] = res_reg[gi+1];
        end
    endgenerate
    assign res_next[DATA_WIDTH-1] = d_bit;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            a_sr_reg <= bus.A;
            b_sr_reg <= bus.B;
            res_reg  <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
        end else if (state_reg == RUN) begin
            a_sr_reg <= a_sr_reg >> 1;
            b_sr_reg <= b_sr_reg >> 1;
            res_reg  <= res_next;
            br_reg   <= br_next;
            cnt_reg  <= cnt_reg + CW'(1);
            // Published result only moves on the completing bit.
            if (last_bit) begin
                diff_reg   <= res_next;
                borrow_reg <= br_next;
            end
        end
    end

    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = (state_reg == DONE);
    assign bus.Diff   = diff_reg;
    assign bus.Borrow = borrow_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at DATA_WIDTH=4 and DATA_WIDTH=8.
// Table-driven single operations plus hand sequences for abort, ignore and back-to-back cases.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.DATA_WIDTH(4)) if4 ();
    serial_subtractor_if #(.DATA_WIDTH(8)) if8 ();

    serial_subtractor #(.DATA_WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    serial_subtractor #(.DATA_WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       borrow;
    } vec4_t;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ed, input logic eb, input string tag);
        int busy_n;
        int seen;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        if4.A = a; if4.B = b; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0; if4.A = ~a; if4.B = ~b;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (if4.busy) busy_n++;
            if (if4.done) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_cycles"}, busy_n, 4);
        check({tag, "_diff"}, int'(if4.Diff), int'(ed));
        check({tag, "_borrow"}, int'(if4.Borrow), int'(eb));
        @(negedge clk);
        check({tag, "_done_pulse_len"}, int'(if4.done), 0);
        check({tag, "_diff_held"}, int'(if4.Diff), int'(ed));
        $display("op4 %s: A=%0d B=%0d Diff=%0d Borrow=%0d", tag, a, b, if4.Diff, if4.Borrow);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input string tag);
        int busy_n;
        int seen;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        if8.A = a; if8.B = b; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0; if8.A = ~a; if8.B = ~b;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (if8.busy) busy_n++;
            if (if8.done) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_cycles"}, busy_n, 8);
        check({tag, "_diff"}, int'(if8.Diff), int'(ed));
        check({tag, "_borrow"}, int'(if8.Borrow), int'(eb));
        @(negedge clk);
        check({tag, "_done_pulse_len"}, int'(if8.done), 0);
        $display("op8 %s: A=%0d B=%0d Diff=%0d Borrow=%0d", tag, a, b, if8.Diff, if8.Borrow);
    endtask

    initial begin
        vec4_t vecs[8];
        int    done_n;
        int    last_cyc;
        int    diff_at_done;

        vecs[0] = '{4'b0110, 4'b0001, 4'b0101, 1'b0};
        vecs[1] = '{4'b0010, 4'b1000, 4'b1010, 1'b1};
        vecs[2] = '{4'b1111, 4'b1111, 4'b0000, 1'b0};
        vecs[3] = '{4'b0000, 4'b0001, 4'b1111, 1'b1};
        vecs[4] = '{4'd9,    4'd3,    4'd6,    1'b0};
        vecs[5] = '{4'd5,    4'd7,    4'd14,   1'b1};
        vecs[6] = '{4'd8,    4'd1,    4'd7,    1'b0};
        vecs[7] = '{4'd3,    4'd12,   4'd7,    1'b1};

        if4.start = 1'b0; if4.A = '0; if4.B = '0;
        if8.start = 1'b0; if8.A = '0; if8.B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(if4.busy), 0);
        check("reset_done", int'(if4.done), 0);
        check("reset_diff", int'(if4.Diff), 0);
        check("reset_borrow", int'(if4.Borrow), 0);
        check("reset_busy8", int'(if8.busy), 0);
        $display("reset: busy=%0d done=%0d Diff=%0d Borrow=%0d", if4.busy, if4.done, if4.Diff, if4.Borrow);

        for (int i = 0; i < 8; i++) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));
        end

        // start during RUN must be ignored
        @(negedge clk);
        if4.A = 4'd9; if4.B = 4'd3; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (2) @(negedge clk);
        if4.A = 4'd1; if4.B = 4'd1; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        done_n = 0;
        diff_at_done = -1;
        for (int i = 0; i < 12; i++) begin
            if (if4.done) begin
                done_n++;
                diff_at_done = int'(if4.Diff);
            end
            @(negedge clk);
        end
        check("ignore_done_count", done_n, 1);
        check("ignore_diff", diff_at_done, 6);
        check("ignore_diff_held", int'(if4.Diff), 6);
        $display("ignore: done pulses=%0d Diff=%0d", done_n, diff_at_done);

        // reset mid-RUN aborts and clears the result
        @(negedge clk);
        if4.A = 4'd5; if4.B = 4'd2; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(if4.busy), 0);
        check("abort_done", int'(if4.done), 0);
        check("abort_diff", int'(if4.Diff), 0);
        check("abort_borrow", int'(if4.Borrow), 0);
        done_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (if4.done) done_n++;
            @(negedge clk);
        end
        check("abort_no_done", done_n, 0);
        $display("abort: busy=%0d Diff=%0d done pulses=%0d", if4.busy, if4.Diff, done_n);
        op4(4'd12, 4'd5, 4'd7, 1'b0, "after_abort");

        // start held high: back-to-back operations
        @(negedge clk);
        if4.A = 4'd5; if4.B = 4'd7; if4.start = 1'b1;
        done_n   = 0;
        last_cyc = -1;
        for (int cyc = 1; cyc <= 27; cyc++) begin
            @(negedge clk);
            if (if4.done) begin
                done_n++;
                check("b2b_diff", int'(if4.Diff), 14);
                check("b2b_borrow", int'(if4.Borrow), 1);
                if (last_cyc >= 0) check("b2b_interval", cyc - last_cyc, 5);
                $display("b2b: done at cycle %0d Diff=%0d Borrow=%0d", cyc, if4.Diff, if4.Borrow);
                last_cyc = cyc;
            end
        end
        if4.start = 1'b0;
        check("b2b_done_count", done_n, 5);
        repeat (8) @(negedge clk);

        op8(8'd6, 8'd1, 8'd5, 1'b0, "w8_basic");
        op8(8'd0, 8'd1, 8'd255, 1'b1, "w8_wrap");
        op8(8'd200, 8'd100, 8'd100, 1'b0, "w8_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
